// File: rtl/slot_mux_pkg.sv
// Shared types, default parameters and helpers for the slot multiplexer sequencer.
package slot_mux_pkg;

  typedef enum logic [1:0] {
    StRun,
    StDrain,
    StRst
  } state_t;

  localparam int unsigned DefNSlots      = 64;
  localparam int unsigned DefIoW         = 12;
  localparam int unsigned DefSyncStages  = 2;
  localparam int unsigned DefDrainCycles = 4;
  localparam int unsigned DefRstCycles   = 8;
  localparam int unsigned DefSelStable   = 16;

  // Out-of-range slot requests fall back to slot 0.
  function automatic int unsigned clamp_sel(input int unsigned sel, input int unsigned n_slots);
    return (sel < n_slots) ? sel : 32'd0;
  endfunction

endpackage

// File: rtl/slot_mux_sync.sv
// Multi-stage input synchroniser for the shared chip input pins; clears to zero on reset.
module slot_mux_sync
  import slot_mux_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = DefSyncStages,
  parameter int unsigned IO_W        = DefIoW
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic [IO_W-1:0] d,
  output logic [IO_W-1:0] q
);

  logic [IO_W-1:0] stage_q [SYNC_STAGES];

  // Shift the pins through the flop chain.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= d;
      for (int i = 1; i < SYNC_STAGES; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign q = stage_q[SYNC_STAGES-1];

endmodule

// File: rtl/slot_mux_sequencer.sv
// Routes the shared chip pins to one of N_SLOTS designs. Every selection change is sequenced:
// the output is drained to zero, the new slot receives a reset pulse, then it is connected.
// Optional build macro SLOTMUX_SEL_FILTER_EN: des_sel must be stable for SEL_STABLE cycles
// before it is accepted as a new selection.
module slot_mux_sequencer
  import slot_mux_pkg::*;
#(
  parameter int unsigned N_SLOTS      = DefNSlots,
  parameter int unsigned IO_W         = DefIoW,
  parameter int unsigned SYNC_STAGES  = DefSyncStages,
  parameter int unsigned DRAIN_CYCLES = DefDrainCycles,
  parameter int unsigned RST_CYCLES   = DefRstCycles,
  parameter int unsigned SEL_STABLE   = DefSelStable,
  parameter int unsigned SEL_W        = $clog2(N_SLOTS)
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic [IO_W-1:0]         io_in,
  output logic [IO_W-1:0]         io_out,
  input  logic [SEL_W-1:0]        des_sel,
  input  logic                    hold_if_not_sel,
  input  logic                    sync_inputs,
  output logic [N_SLOTS*IO_W-1:0] des_io_in,
  input  logic [N_SLOTS*IO_W-1:0] des_io_out,
  output logic [N_SLOTS-1:0]      des_reset,
  output logic [SEL_W-1:0]        active_sel,
  output logic                    switching
);

  localparam int unsigned CntMax = (DRAIN_CYCLES > RST_CYCLES) ? DRAIN_CYCLES : RST_CYCLES;
  localparam int unsigned CntW   = $clog2(CntMax + 1);
  // Counter holds remaining cycles minus one, so each state lasts exactly its cycle count.
  localparam logic [CntW-1:0] DrainLoad = CntW'(DRAIN_CYCLES - 1);
  localparam logic [CntW-1:0] RstLoad   = CntW'(RST_CYCLES - 1);

  state_t           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [SEL_W-1:0] active_q, active_d;
  logic             first_q, first_d;
  logic [IO_W-1:0]  io_out_d;
  logic [IO_W-1:0]  sync_q;
  logic [IO_W-1:0]  in_path;
  logic [SEL_W-1:0] sel_clamped;
  logic [SEL_W-1:0] sel_accepted;
  logic [IO_W-1:0]  slot_out [N_SLOTS];

  slot_mux_sync #(
    .SYNC_STAGES(SYNC_STAGES),
    .IO_W       (IO_W)
  ) u_sync (
    .clock  (clock),
    .reset_n(reset_n),
    .d      (io_in),
    .q      (sync_q)
  );

  // Path select is deliberately unprotected; toggling sync_inputs may glitch des_io_in.
  assign in_path     = sync_inputs ? sync_q : io_in;
  assign sel_clamped = SEL_W'(clamp_sel(32'(des_sel), N_SLOTS));

`ifdef SLOTMUX_SEL_FILTER_EN
  localparam int unsigned StabW = $clog2(SEL_STABLE + 1);
  localparam logic [StabW-1:0] StabFull = StabW'(SEL_STABLE);

  logic [SEL_W-1:0] cand_q, cand_d, acc_q;
  logic [StabW-1:0] stab_q, stab_d;

  // Track how long the current candidate has been requested; any change restarts the count.
  always_comb begin
    cand_d = cand_q;
    stab_d = stab_q;
    if (first_q) begin
      // The power-on selection is taken as already stable.
      cand_d = sel_clamped;
      stab_d = StabFull;
    end else if (sel_clamped != cand_q) begin
      cand_d = sel_clamped;
      stab_d = StabW'(1);
    end else if (stab_q != StabFull) begin
      stab_d = stab_q + 1'b1;
    end
  end

  assign sel_accepted = (stab_q == StabFull) ? cand_q : acc_q;

  // Filter state registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cand_q <= '0;
      stab_q <= '0;
      acc_q  <= '0;
    end else begin
      cand_q <= cand_d;
      stab_q <= stab_d;
      acc_q  <= sel_accepted;
    end
  end
`else
  assign sel_accepted = sel_clamped;
`endif

  // Sequencer next-state: quiesce, switch, reset the new slot, then connect it.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    active_d = active_q;
    first_d  = first_q;
    unique case (state_q)
      StRst: begin
        if (first_q) begin
          // First clock after reset: latch the requested slot and start a full reset pulse.
          first_d  = 1'b0;
          active_d = sel_clamped;
          cnt_d    = RstLoad;
        end else if (cnt_q == '0) begin
          state_d = StRun;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StRun: begin
        if (sel_accepted != active_q) begin
          state_d = StDrain;
          cnt_d   = DrainLoad;
        end
      end
      StDrain: begin
        if (cnt_q == '0) begin
          active_d = sel_accepted;
          state_d  = StRst;
          cnt_d    = RstLoad;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = StRst;
        cnt_d   = RstLoad;
      end
    endcase
  end

  assign io_out_d = (state_q == StRun) ? slot_out[active_q] : '0;

  // Sequencer state and registered pin output.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= StRst;
      cnt_q    <= '0;
      active_q <= '0;
      first_q  <= 1'b1;
      io_out   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      active_q <= active_d;
      first_q  <= first_d;
      io_out   <= io_out_d;
    end
  end

  assign active_sel = active_q;
  assign switching  = (state_q != StRun);

  for (genvar s = 0; s < N_SLOTS; s++) begin : g_slot
    logic is_active;
    assign is_active   = (active_q == SEL_W'(s));
    assign slot_out[s] = des_io_out[s*IO_W +: IO_W];
    assign des_io_in[s*IO_W +: IO_W] = (is_active || !hold_if_not_sel) ? in_path : '0;
    // Until the first selection is latched every slot stays in reset.
    assign des_reset[s] = first_q | (is_active ? (state_q == StRst) : hold_if_not_sel);
  end

endmodule

// File: tb/tb_slot_mux_sequencer.sv
// Directed bench for slot_mux_sequencer with an io_out scoreboard.
module tb_slot_mux_sequencer;

  localparam int unsigned N  = 64;
  localparam int unsigned W  = 12;
  localparam int unsigned SW = 6;
`ifdef SLOTMUX_SEL_FILTER_EN
  localparam int AcceptTicks = 17;
`else
  localparam int AcceptTicks = 1;
`endif

  logic           clock = 1'b0;
  logic           reset_n;
  logic [W-1:0]   io_in;
  logic [W-1:0]   io_out;
  logic [SW-1:0]  des_sel;
  logic           hold_if_not_sel;
  logic           sync_inputs;
  logic [N*W-1:0] des_io_in;
  logic [N*W-1:0] des_io_out;
  logic [N-1:0]   des_reset;
  logic [SW-1:0]  active_sel;
  logic           switching;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q [$];

  slot_mux_sequencer dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .io_in          (io_in),
    .io_out         (io_out),
    .des_sel        (des_sel),
    .hold_if_not_sel(hold_if_not_sel),
    .sync_inputs    (sync_inputs),
    .des_io_in      (des_io_in),
    .des_io_out     (des_io_out),
    .des_reset      (des_reset),
    .active_sel     (active_sel),
    .switching      (switching)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [W-1:0] slot_in(input int s);
    return des_io_in[s*W +: W];
  endfunction

  task automatic drive_outs();
    for (int s = 0; s < int'(N); s++) des_io_out[s*W +: W] = W'($urandom);
  endtask

  // One RUN cycle: drive slot s, queue its value, expect it on io_out after the edge.
  task automatic sb_cycle(input int s, input string tag);
    logic [W-1:0] v;
    v = W'($urandom);
    drive_outs();
    des_io_out[s*W +: W] = v;
    exp_q.push_back(v);
    tick();
    check(tag, io_out, exp_q.pop_front());
  endtask

  initial begin
    int n;
    int k_wait;
    logic ok;
    logic [W-1:0] vold;

    reset_n = 1'b0;
    des_sel = SW'(5);
    hold_if_not_sel = 1'b1;
    sync_inputs = 1'b0;
    io_in = '0;
    des_io_out = '0;
    tick();
    tick();
    check("rst_io_out", io_out, 0);
    check("rst_des_reset", des_reset, 64'hFFFF_FFFF_FFFF_FFFF);
    check("rst_switching", switching, 1);
    check("rst_active", active_sel, 0);

    // 1: power-on selection of slot 5
    reset_n = 1'b1;
    tick();
    check("t1_active", active_sel, 5);
    n = 0;
    for (int k = 0; k < 50 && switching; k++) begin
      if (des_reset[5]) n++;
      tick();
    end
    check("t1_switch_fall", switching, 0);
    check("t1_rst_len", n, 8);
    check("t1_rst_low", des_reset[5], 0);
    for (int i = 0; i < 6; i++) sb_cycle(5, "t1_io_out");

    // 2: switch 5 -> 11
    io_in = 12'h5A5;
    des_sel = SW'(11);
    k_wait = 0;
    vold = '0;
    while (!switching && k_wait < 40) begin
      vold = W'($urandom);
      drive_outs();
      des_io_out[5*W +: W] = vold;
      tick();
      k_wait++;
    end
    check("t2_accept_ticks", k_wait, AcceptTicks);
    check("t2_last_old", io_out, vold);
    n = 0;
    ok = 1'b1;
    while (active_sel == SW'(5) && n < 50) begin
      drive_outs();
      tick();
      n++;
      if (io_out !== '0) ok = 1'b0;
    end
    check("t2_drain_len", n, 4);
    check("t2_drain_zero", ok, 1);
    check("t2_new_active", active_sel, 11);

    // 3: selection glitches during RST are ignored
    n = 0;
    for (int k = 0; k < 50 && switching; k++) begin
      if (des_reset[11]) n++;
      if (k == 2) des_sel = SW'(20);
      if (k == 4) des_sel = SW'(11);
      drive_outs();
      tick();
    end
    check("t2_rst_len", n, 8);
    check("t2_old_held", des_reset[5], 1);
    check("t2_old_zero_in", slot_in(5), 0);
    ok = 1'b1;
    for (int i = 0; i < 5; i++) begin
      sb_cycle(11, "t3_io_out");
      if (switching) ok = 1'b0;
    end
    check("t3_no_drain", ok, 1);
    check("t3_active", active_sel, 11);

    // 4: synchronised vs direct input path
    io_in = '0;
    sync_inputs = 1'b1;
    tick();
    tick();
    tick();
    check("t4_sync_flush", slot_in(11), 0);
    io_in = 12'hA5A;
    #1;
    check("t4_sync_d0", slot_in(11), 0);
    tick();
    check("t4_sync_d1", slot_in(11), 0);
    tick();
    check("t4_sync_d2", slot_in(11), 12'hA5A);
    sync_inputs = 1'b0;
    io_in = 12'h3C3;
    #1;
    check("t4_comb", slot_in(11), 12'h3C3);

    // 5: idle slot handling
    hold_if_not_sel = 1'b0;
    #1;
    check("t5_free_in", slot_in(5), 12'h3C3);
    check("t5_free_rst", des_reset[5], 0);
    check("t5_free_rst63", des_reset[63], 0);
    check("t5_sel_rst", des_reset[11], 0);
    hold_if_not_sel = 1'b1;
    #1;
    check("t5_hold_in", slot_in(5), 0);
    check("t5_hold_rst", des_reset[5], 1);
    check("t5_sel_in", slot_in(11), 12'h3C3);

`ifdef SLOTMUX_SEL_FILTER_EN
    // 6: unstable requests never switch
    ok = 1'b1;
    for (int r = 0; r < 6; r++) begin
      des_sel = (r % 2 == 0) ? SW'(30) : SW'(11);
      for (int c = 0; c < 10; c++) begin
        tick();
        if (switching) ok = 1'b0;
      end
    end
    check("t6_no_switch", ok, 1);
    check("t6_active", active_sel, 11);
`endif

    // 7: asynchronous reset in the middle of DRAIN
    des_sel = SW'(30);
    k_wait = 0;
    while (!switching && k_wait < 40) begin
      tick();
      k_wait++;
    end
    check("t7_accept_ticks", k_wait, AcceptTicks);
    tick();
    check("t7_in_drain", active_sel, 11);
    #2;
    reset_n = 1'b0;
    #1;
    check("t7_active", active_sel, 0);
    check("t7_io_out", io_out, 0);
    check("t7_des_reset", des_reset, 64'hFFFF_FFFF_FFFF_FFFF);
    check("t7_switching", switching, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
